sine_phase_tracker: RTL and testbench

- Receive-side counterpart to the digital sine generator: consumes the sampled magnitude and complementary sign pair (sign/signB) of a sine stream.
- Recovers half-period length (in samples) and per-half-cycle peak magnitude.
- Declares lock when consecutive half-periods agree, and flags sign-pair or timeout faults.
- Sits at the measurement/loopback end of the current-generator chain, feeding calibration and status logic.

---
 rtl/digital_sine_pkg.sv | 13 +
 rtl/sine_phase_tracker_if.sv | 29 ++
 rtl/sine_phase_tracker_meter.sv | 50 +++++
 rtl/sine_phase_tracker.sv | 159 +++++++++++++++
 tb/tb_sine_phase_tracker.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/digital_sine_pkg.sv
// Shared types and constants for the sine phase tracker slice.
package digital_sine_pkg;

    typedef enum logic [2:0] {SEARCH, SYNC, ACQ, LOCKED, FAULT} state_t;

    localparam logic [1:0] FLT_NONE    = 2'b00;
    localparam logic [1:0] FLT_SIGN    = 2'b01;
    localparam logic [1:0] FLT_TIMEOUT = 2'b10;

    localparam int DEF_MAG_W = 33;
    localparam int DEF_CNT_W = 16;

endpackage

// File: rtl/sine_phase_tracker_if.sv
// Sample stream in, half-cycle measurements and status out.
interface sine_phase_tracker_if
    import digital_sine_pkg::*;
#(
    parameter int MAG_W = DEF_MAG_W,
    parameter int CNT_W = DEF_CNT_W
);
    logic             sample_valid;
    logic             sign;
    logic             signB;
    logic [MAG_W-1:0] mag;
    logic             clear_fault;
    logic [CNT_W-1:0] half_period;
    logic [MAG_W-1:0] peak;
    logic             meas_valid;
    logic             locked;
    logic             fault;
    logic [1:0]       fault_code;

    modport master (
        output sample_valid, sign, signB, mag, clear_fault,
        input  half_period, peak, meas_valid, locked, fault, fault_code
    );

    modport slave (
        input  sample_valid, sign, signB, mag, clear_fault,
        output half_period, peak, meas_valid, locked, fault, fault_code
    );
endinterface

// File: rtl/sine_phase_tracker_meter.sv
// half_cycle_meter: per-half-cycle sample counter, running peak and
// boundary/timeout detection; sequencing is owned by the tracker FSM.
module half_cycle_meter
    import digital_sine_pkg::*;
#(
    parameter int MAG_W   = DEF_MAG_W,
    parameter int CNT_W   = DEF_CNT_W,
    parameter int TIMEOUT = 65535
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic             clr,
    input  logic             sign,
    input  logic [MAG_W-1:0] mag,
    output logic             boundary,
    output logic             timeout,
    output logic [CNT_W-1:0] cnt,
    output logic [MAG_W-1:0] pk_run
);
    localparam logic [CNT_W-1:0] TO_M1 = CNT_W'(TIMEOUT - 1);

    logic sign_q;

    assign boundary = (sign != sign_q);
    // Flags the sample that would bring the count up to TIMEOUT.
    assign timeout  = !boundary && (cnt >= TO_M1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            pk_run <= '0;
            sign_q <= 1'b0;
        end else if (clr) begin
            cnt    <= '0;
            pk_run <= '0;
            sign_q <= 1'b0;
        end else if (load) begin
            cnt    <= CNT_W'(1);
            pk_run <= mag;
            sign_q <= sign;
        end else if (step) begin
            if (cnt != '1)
                cnt <= cnt + 1'b1;
            if (mag > pk_run)
                pk_run <= mag;
        end
    end
endmodule

// File: rtl/sine_phase_tracker.sv
// Recovers half-period and peak from a sign/magnitude sine stream,
// tracks lock on consistent half-periods and latches sign/timeout faults.
module sine_phase_tracker
    import digital_sine_pkg::*;
#(
    parameter int MAG_W      = DEF_MAG_W,
    parameter int CNT_W      = DEF_CNT_W,
    parameter int LOCK_COUNT = 4,
    parameter int TOL        = 2,
    parameter int TIMEOUT    = 65535
) (
    input  logic                 clk,
    input  logic                 rst,
    sine_phase_tracker_if.slave  bus
);
    localparam int               MW      = $clog2(LOCK_COUNT + 1);
    localparam logic [MW-1:0]    LOCK_N  = MW'(LOCK_COUNT);
    localparam logic [MW-1:0]    LOCK_M1 = MW'(LOCK_COUNT - 1);
    localparam logic [CNT_W-1:0] TOL_C   = CNT_W'(TOL);

    state_t           state, state_n;
    logic [CNT_W-1:0] half_period_q, half_period_n;
    logic [MAG_W-1:0] peak_q, peak_n;
    logic [CNT_W-1:0] prev_q, prev_n, diff;
    logic [MW-1:0]    match_q, match_n;
    logic [1:0]       code_q, code_n;
    logic             meas_q, meas_n, first_q, first_n;
    logic             m_load, m_step, m_clr, boundary, timeout, sign_err;
    logic [CNT_W-1:0] cnt;
    logic [MAG_W-1:0] pk_run;

    half_cycle_meter #(.MAG_W(MAG_W), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) u_meter (
        .clk      (clk),
        .rst      (rst),
        .load     (m_load),
        .step     (m_step),
        .clr      (m_clr),
        .sign     (bus.sign),
        .mag      (bus.mag),
        .boundary (boundary),
        .timeout  (timeout),
        .cnt      (cnt),
        .pk_run   (pk_run)
    );

    assign sign_err = (bus.sign == bus.signB);
    assign diff     = (cnt >= prev_q) ? cnt - prev_q : prev_q - cnt;

    always_comb begin
        state_n       = state;
        half_period_n = half_period_q;
        peak_n        = peak_q;
        prev_n        = prev_q;
        match_n       = match_q;
        code_n        = code_q;
        first_n       = first_q;
        meas_n        = 1'b0;
        m_load        = 1'b0;
        m_step        = 1'b0;
        m_clr         = 1'b0;
        case (state)
            SEARCH: if (bus.sample_valid) begin
                if (sign_err) begin
                    state_n = FAULT;
                    code_n  = FLT_SIGN;
                end else begin
                    m_load  = 1'b1;
                    state_n = SYNC;
                end
            end
            SYNC: if (bus.sample_valid) begin
                if (sign_err) begin
                    state_n = FAULT;
                    code_n  = FLT_SIGN;
                end else if (boundary) begin
                    // The partial half-cycle seen from SEARCH is thrown away.
                    m_load  = 1'b1;
                    first_n = 1'b1;
                    state_n = ACQ;
                end else if (timeout) begin
                    state_n = FAULT;
                    code_n  = FLT_TIMEOUT;
                end else begin
                    m_step = 1'b1;
                end
            end
            ACQ, LOCKED: if (bus.sample_valid) begin
                if (sign_err) begin
                    state_n = FAULT;
                    code_n  = FLT_SIGN;
                end else if (boundary) begin
                    half_period_n = cnt;
                    peak_n        = pk_run;
                    meas_n        = 1'b1;
                    m_load        = 1'b1;
                    prev_n        = cnt;
                    if (first_q) begin
                        first_n = 1'b0;
                        match_n = '0;
                    end else if (diff <= TOL_C) begin
                        // Saturate at LOCK_N so a long lock never wraps.
                        if (match_q >= LOCK_M1) begin
                            match_n = LOCK_N;
                            state_n = LOCKED;
                        end else begin
                            match_n = match_q + 1'b1;
                        end
                    end else begin
                        match_n = '0;
                        state_n = ACQ;
                    end
                end else if (timeout) begin
                    state_n = FAULT;
                    code_n  = FLT_TIMEOUT;
                end else begin
                    m_step = 1'b1;
                end
            end
            FAULT: if (bus.clear_fault) begin
                state_n = SEARCH;
                code_n  = FLT_NONE;
                match_n = '0;
                prev_n  = '0;
                first_n = 1'b0;
                m_clr   = 1'b1;
            end
            default: state_n = SEARCH;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= SEARCH;
            half_period_q <= '0;
            peak_q        <= '0;
            prev_q        <= '0;
            match_q       <= '0;
            code_q        <= FLT_NONE;
            first_q       <= 1'b0;
            meas_q        <= 1'b0;
        end else begin
            state         <= state_n;
            half_period_q <= half_period_n;
            peak_q        <= peak_n;
            prev_q        <= prev_n;
            match_q       <= match_n;
            code_q        <= code_n;
            first_q       <= first_n;
            meas_q        <= meas_n;
        end
    end

    assign bus.half_period = half_period_q;
    assign bus.peak        = peak_q;
    assign bus.meas_valid  = meas_q;
    assign bus.locked      = (state == LOCKED);
    assign bus.fault       = (state == FAULT);
    assign bus.fault_code  = code_q;
endmodule

// File: tb/tb_sine_phase_tracker.sv
// Directed scoreboard bench for sine_phase_tracker (TIMEOUT=20).
module tb_sine_phase_tracker;
    import digital_sine_pkg::*;

    localparam int MAG_W = 33;
    localparam int CNT_W = 16;

    typedef struct {
        logic [CNT_W-1:0] hp;
        logic [MAG_W-1:0] pk;
        logic             lk;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic cur = 1'b1;
    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    sine_phase_tracker_if #(.MAG_W(MAG_W), .CNT_W(CNT_W)) bus ();

    sine_phase_tracker #(
        .MAG_W(MAG_W), .CNT_W(CNT_W), .LOCK_COUNT(4), .TOL(2), .TIMEOUT(20)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One valid sample, then `gap` idle cycles with junk on sign/mag.
    task automatic samp(input logic s, input logic sb, input logic [MAG_W-1:0] m, input int gap);
        bus.sample_valid = 1'b1;
        bus.sign         = s;
        bus.signB        = sb;
        bus.mag          = m;
        @(posedge clk); #1;
        bus.sample_valid = 1'b0;
        for (int g = 0; g < gap; g++) begin
            bus.sign = ~bus.sign;
            bus.mag  = '1;
            @(posedge clk); #1;
        end
    endtask

    // Half-cycle of len samples with mag 0..len-1; its measurement appears
    // at the first sample of the following half.
    task automatic half(input int len, input bit push, input bit lk, input int gap = 0);
        for (int i = 0; i < len; i++) samp(cur, ~cur, MAG_W'(i), gap);
        if (push) sbq.push_back(exp_t'{CNT_W'(len), MAG_W'(len - 1), lk});
        cur = ~cur;
    endtask

    // 20 same-sign samples starting on a boundary; the 20th may also be a sign-pair error.
    task automatic tmo(input bit bad_pair, input logic [1:0] exp_code);
        for (int i = 0; i < 19; i++) samp(cur, ~cur, MAG_W'(i), 0);
        chk("fault_before_timeout", bus.fault, 1'b0);
        samp(cur, bad_pair ? cur : ~cur, MAG_W'(0), 0);
        chk("fault_at_timeout", bus.fault, 1'b1);
        chk("fault_code_at_timeout", bus.fault_code, exp_code);
        chk("locked_at_timeout", bus.locked, 1'b0);
    endtask

    task automatic clear();
        bus.clear_fault  = 1'b1;
        bus.sample_valid = 1'b1;
        bus.sign         = ~cur;
        bus.signB        = cur;
        @(posedge clk); #1;
        bus.clear_fault  = 1'b0;
        bus.sample_valid = 1'b0;
        cur = 1'b1;
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (bus.meas_valid) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_meas: got meas_valid half_period=%0d, expected none",
                         bus.half_period);
            end else begin
                e = sbq.pop_front();
                chk("meas_half_period", bus.half_period, e.hp);
                chk("meas_peak", bus.peak, e.pk);
                chk("meas_locked", bus.locked, e.lk);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1);
    end

    initial begin
        bus.sample_valid = 1'b0;
        bus.sign         = 1'b0;
        bus.signB        = 1'b1;
        bus.mag          = '0;
        bus.clear_fault  = 1'b0;
        #2 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_half_period", bus.half_period, 0);
        chk("rst_peak", bus.peak, 0);
        chk("rst_meas_valid", bus.meas_valid, 0);
        chk("rst_locked", bus.locked, 0);
        chk("rst_fault", bus.fault, 0);
        chk("rst_fault_code", bus.fault_code, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Clean 8/8 triangle: reference, four matches, lock on the 5th.
        half(8, 0, 0);
        repeat (4) half(8, 1, 0);
        half(8, 1, 1);
        half(8, 1, 1);
        chk("locked_after_5_meas", bus.locked, 1'b1);

        // An 11-sample half drops lock; 8 after it mismatches, then four matches.
        half(11, 1, 0);
        half(8, 1, 0);
        repeat (3) half(8, 1, 0);
        half(8, 1, 1);

        // 11 breaks lock, then 10/8 alternation is within TOL and re-locks.
        half(11, 1, 0);
        half(10, 1, 0);
        half(8, 1, 0);
        half(10, 1, 0);
        half(8, 1, 1);
        half(10, 1, 1);

        // 13 breaks lock, then 8/11 alternation never matches.
        half(13, 1, 0);
        repeat (3) begin
            half(8, 1, 0);
            half(11, 1, 0);
        end
        chk("no_lock_8_11", bus.locked, 1'b0);

        // Re-lock on 8s, then a sign-pair error while locked.
        repeat (4) half(8, 1, 0);
        half(8, 1, 1);
        samp(cur, ~cur, MAG_W'(0), 0);
        chk("locked_before_sign_err", bus.locked, 1'b1);
        samp(1'b1, 1'b1, MAG_W'(5), 0);
        chk("sign_err_fault", bus.fault, 1'b1);
        chk("sign_err_code", bus.fault_code, FLT_SIGN);
        chk("sign_err_locked", bus.locked, 1'b0);
        samp(1'b0, 1'b1, MAG_W'(3), 0);
        samp(1'b1, 1'b0, MAG_W'(3), 0);
        chk("fault_holds", bus.fault, 1'b1);
        chk("fault_code_holds", bus.fault_code, FLT_SIGN);
        clear();
        chk("clear_fault", bus.fault, 1'b0);
        chk("clear_code", bus.fault_code, FLT_NONE);
        chk("clear_keeps_half_period", bus.half_period, 8);
        chk("clear_keeps_peak", bus.peak, 7);

        // Lock restarts from SEARCH, then timeout while locked.
        half(8, 0, 0);
        repeat (4) half(8, 1, 0);
        half(8, 1, 1);
        half(8, 1, 1);
        tmo(1'b0, FLT_TIMEOUT);
        clear();

        // Timeout sample that is also a sign-pair error reports sign-pair.
        half(8, 0, 0);
        half(8, 1, 0);
        tmo(1'b1, FLT_SIGN);
        clear();

        // Gaps between samples do not change the measured half-period.
        half(8, 0, 0, 1);
        half(8, 1, 0, 2);
        half(8, 0, 0, 1);
        samp(cur, ~cur, MAG_W'(0), 0);
        chk("meas_pending_before_rst", bus.meas_valid, 1'b1);
        #1 rst = 1'b1;
        #1;
        chk("async_rst_meas_valid", bus.meas_valid, 0);
        chk("async_rst_half_period", bus.half_period, 0);
        chk("async_rst_peak", bus.peak, 0);
        chk("async_rst_locked", bus.locked, 0);
        chk("async_rst_fault", bus.fault, 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("scoreboard_drained", sbq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
